// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and widths for the data-memory responder
package dmem_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int BE_WIDTH   = 4;
    localparam int CNT_WIDTH  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word-addressed storage with byte-enable write and combinational read
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [BE_WIDTH-1:0]   be,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (we && be[i]) begin
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency load/store responder; DMEM_MISALIGN_CHECK_EN rejects unaligned accesses
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    state_t                 state, next_state;
    logic [CNT_WIDTH-1:0]   cnt;
    logic                   cap_write;
    logic [31:0]            cap_addr, cap_wdata;
    logic [3:0]             cap_be;
    logic                   accept, commit;
    logic                   cur_write;
    logic [31:0]            cur_addr, cur_wdata;
    logic [3:0]             cur_be;
    logic                   range_err, align_err, acc_err;
    logic [ADDR_WIDTH-1:0]  widx;
    logic [DATA_WIDTH-1:0]  arr_rdata;
    logic                   arr_we;

    assign accept = (state == IDLE) && req_valid;
    assign commit = (state == IDLE) ? (accept && (LATENCY == 1))
                                    : ((state == WAIT) && (cnt == CNT_WIDTH'(1)));

    // With LATENCY = 1 the commit happens on the accepting edge, before capture.
    assign cur_write = (state == IDLE) ? req_write : cap_write;
    assign cur_addr  = (state == IDLE) ? req_addr  : cap_addr;
    assign cur_wdata = (state == IDLE) ? req_wdata : cap_wdata;
    assign cur_be    = (state == IDLE) ? req_be    : cap_be;

    assign range_err = (cur_addr >> (ADDR_WIDTH + 2)) != 32'd0;
`ifdef DMEM_MISALIGN_CHECK_EN
    assign align_err = (cur_addr[1:0] != 2'b00) && (!cur_write || (cur_be != 4'b0000));
`else
    assign align_err = 1'b0;
`endif
    assign acc_err = range_err | align_err;
    assign widx    = cur_addr[ADDR_WIDTH+1:2];
    assign arr_we  = commit & cur_write & ~acc_err;

    dmem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .be    (cur_be),
        .waddr (widx),
        .raddr (widx),
        .wdata (cur_wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = (LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (cnt == CNT_WIDTH'(1)) next_state = RESP;
            RESP:    if (resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            cap_write  <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_be     <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                cnt       <= CNT_WIDTH'(LATENCY - 1);
                cap_write <= req_write;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                cap_be    <= req_be;
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_WIDTH'(1);
            end
            if (commit) begin
                resp_err   <= acc_err;
                resp_rdata <= (cur_write || acc_err) ? '0 : arr_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder at LATENCY 2 and 4 against a transaction-level model
module tb_dmem_responder;

    localparam int AW    = 10;
    localparam int LAT_A = 2;
    localparam int LAT_B = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rv [2];
    logic        rw;
    logic [31:0] ra, wd;
    logic [3:0]  rbe;
    logic        rrdy;
    logic        qr [2];
    logic        vv [2];
    logic        er [2];
    logic [31:0] rd [2];

    int lat [2] = '{LAT_A, LAT_B};

    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT_A)) dut_a (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(qr[0]), .req_write(rw),
        .req_addr(ra), .req_wdata(wd), .req_be(rbe), .resp_valid(vv[0]),
        .resp_ready(rrdy), .resp_rdata(rd[0]), .resp_err(er[0])
    );

    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT_B)) dut_b (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(qr[1]), .req_write(rw),
        .req_addr(ra), .req_wdata(wd), .req_be(rbe), .resp_valid(vv[1]),
        .resp_ready(rrdy), .resp_rdata(rd[1]), .resp_err(er[1])
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, required %h", nm, act, exp);
    endtask

    // Transaction-level model: an accepted op is outstanding until its response handshake,
    // becomes visible LATENCY cycles after acceptance, and lands in memory just before that.
    bit          pend [2] = '{0, 0};
    bit          comm [2] = '{0, 0};
    bit          rdk  [2] = '{0, 0};
    int          due  [2] = '{0, 0};
    logic        op_w [2];
    logic [31:0] op_a [2], op_d [2];
    logic [3:0]  op_be [2];
    logic [31:0] exp_rd [2];
    logic        exp_er [2];
    logic [31:0] mm [2][1024];
    bit          mk [2][1024];
    int          cyc = 0;
    bit          armed = 0;

    task automatic commit_op(input int l);
        int   idx;
        logic e;
        idx = int'((op_a[l] / 4) % 1024);
        e   = (op_a[l] >= 32'h1000);
`ifdef DMEM_MISALIGN_CHECK_EN
        if ((op_a[l] % 4) != 0 && (!op_w[l] || op_be[l] != 4'h0)) e = 1'b1;
`endif
        exp_er[l] = e;
        exp_rd[l] = 32'd0;
        rdk[l]    = 1'b1;
        if (!e && op_w[l]) begin
            for (int b = 0; b < 4; b++)
                if (op_be[l][b]) mm[l][idx][8*b +: 8] = op_d[l][8*b +: 8];
            if (op_be[l] == 4'hF) mk[l][idx] = 1'b1;
        end else if (!e) begin
            exp_rd[l] = mm[l][idx];
            rdk[l]    = mk[l][idx];
        end
        comm[l] = 1'b1;
    endtask

    always begin
        @(posedge clk or posedge rst);
        if (rst) begin
            for (int l = 0; l < 2; l++) pend[l] = 1'b0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (pend[l] && cyc >= due[l] && rrdy) begin
                    pend[l] = 1'b0;
                end else if (!pend[l] && rv[l]) begin
                    pend[l]  = 1'b1;
                    comm[l]  = 1'b0;
                    due[l]   = cyc + lat[l];
                    op_w[l]  = rw;
                    op_a[l]  = ra;
                    op_d[l]  = wd;
                    op_be[l] = rbe;
                end
                if (pend[l] && !comm[l] && cyc + 1 == due[l]) commit_op(l);
            end
            cyc++;
        end
    end

    always begin
        bit ev;
        @(negedge clk);
        if (armed && !rst) begin
            for (int l = 0; l < 2; l++) begin
                ev = pend[l] && cyc >= due[l];
                chk($sformatf("req_ready[%0d]", l), 32'(qr[l]), 32'(!pend[l]));
                chk($sformatf("resp_valid[%0d]", l), 32'(vv[l]), 32'(ev));
                if (ev) begin
                    chk($sformatf("resp_err[%0d]", l), 32'(er[l]), 32'(exp_er[l]));
                    if (rdk[l]) chk($sformatf("resp_rdata[%0d]", l), rd[l], exp_rd[l]);
                end
            end
        end
    end

    task automatic xact(input int l, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input int hold,
                        output logic [31:0] r, output logic e);
        int t;
        @(negedge clk);
        rw = w; ra = a; wd = d; rbe = b; rv[l] = 1'b1; rrdy = (hold == 0);
        @(negedge clk);
        rv[l] = 1'b0; rw = ~w; ra = ~a; wd = ~d; rbe = ~b;
        t = 1;
        while (!vv[l] && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("latency[%0d]", l), 32'(t), 32'(lat[l]));
        r = rd[l];
        e = er[l];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(vv[l]), 32'd1);
            chk("hold_rdata", rd[l], r);
            chk("hold_req_ready", 32'(qr[l]), 32'd0);
        end
        rrdy = 1'b1;
        @(negedge clk);
        chk("ready_after_resp", 32'(qr[l]), 32'd1);
        chk("valid_after_resp", 32'(vv[l]), 32'd0);
    endtask

    task automatic chk_reset_vals(input string nm);
        for (int l = 0; l < 2; l++) begin
            chk({nm, "_req_ready"}, 32'(qr[l]), 32'd1);
            chk({nm, "_resp_valid"}, 32'(vv[l]), 32'd0);
            chk({nm, "_resp_rdata"}, rd[l], 32'd0);
            chk({nm, "_resp_err"}, 32'(er[l]), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        rv[0] = 1'b0; rv[1] = 1'b0; rw = 1'b0; ra = '0; wd = '0; rbe = '0; rrdy = 1'b1;
        #1;
        chk_reset_vals("por");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        armed = 1'b1;

        xact(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, r, e);
        chk("st10_err", 32'(e), 32'd0);
        chk("st10_rdata", r, 32'd0);
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, r, e);
        chk("ld10_rdata", r, 32'hDEAD_BEEF);
        chk("ld10_err", 32'(e), 32'd0);
        xact(0, 1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 0, r, e);
        xact(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, r, e);
        chk("merge_rdata", r, 32'hDEAD_BEAA);

        xact(0, 1'b1, 32'h0, 32'h1122_3344, 4'hF, 0, r, e);
        xact(0, 1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, 0, r, e);
        chk("oor_st_err", 32'(e), 32'd1);
        xact(0, 1'b0, 32'h1000, 32'h0, 4'h0, 0, r, e);
        chk("oor_ld_err", 32'(e), 32'd1);
        chk("oor_ld_rdata", r, 32'd0);
        xact(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, r, e);
        chk("word0_kept", r, 32'h1122_3344);
        xact(0, 1'b1, 32'h0, 32'h5555_5555, 4'h0, 0, r, e);
        chk("be0_err", 32'(e), 32'd0);
        xact(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, r, e);
        chk("be0_kept", r, 32'h1122_3344);

        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, r, e);
        chk("bp_rdata", r, 32'hDEAD_BEAA);

        xact(0, 1'b0, 32'h12, 32'h0, 4'h0, 0, r, e);
`ifdef DMEM_MISALIGN_CHECK_EN
        chk("mis_err", 32'(e), 32'd1);
        chk("mis_rdata", r, 32'd0);
`else
        chk("mis_err", 32'(e), 32'd0);
        chk("mis_rdata", r, 32'hDEAD_BEAA);
`endif

        xact(1, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 0, r, e);
        xact(1, 1'b0, 32'h20, 32'h0, 4'h0, 0, r, e);
        chk("ld20_rdata", r, 32'hCAFE_F00D);

        @(negedge clk);
        rw = 1'b1; ra = 32'h20; wd = 32'h1234_5678; rbe = 4'hF; rv[1] = 1'b1;
        @(negedge clk);
        rv[1] = 1'b0;
        #2 rst = 1'b1;
        #1 chk_reset_vals("midrst");
        @(negedge clk);
        #2 rst = 1'b0;
        xact(1, 1'b0, 32'h20, 32'h0, 4'h0, 0, r, e);
        chk("ld20_after_rst", r, 32'hCAFE_F00D);

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

endmodule
